// File: rtl/seq_divider16.sv
// seq_divider16: 16-step restoring sequential divider with divide-by-zero flag.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_nx, quo_nx, dvd_mag, dvs_mag, q_fin, r_fin;
    logic [WIDTH:0]   upper, diff;
    logic [4:0]       cnt;
    logic             last;
    logic             accept, div0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_q, neg_r;
`endif
    assign accept = state == IDLE && start;
    assign div0   = divisor == '0;
    assign busy   = state != IDLE;
    assign done   = state == FINISH;
    always_comb begin
        upper  = {rem, quo[WIDTH-1]};
        diff   = upper - {1'b0, dvs};
        rem_nx = diff[WIDTH] ? upper[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
        q_fin   = neg_q ? -quo : quo;
        r_fin   = neg_r ? -rem : rem;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_fin   = quo;
        r_fin   = rem;
`endif
    end
    always_comb begin
        state_nx = state;
        state_nx = accept ? (div0 ? FINISH : RUN) :
                   (state == RUN && last) ? FINISH :
                   (state == FINISH) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // After the last step, one extra RUN cycle applies sign fixup and publishes results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            cnt  <= '0;
            last <= 1'b0;
            rem  <= '0;
            quo  <= dvd_mag;
            dvs  <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
            if (div0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            if (!last) begin
                rem  <= rem_nx;
                quo  <= quo_nx;
                cnt  <= cnt == 5'(WIDTH-1) ? cnt : cnt + 5'd1;
                last <= cnt == 5'(WIDTH-1);
            end else begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: vector table, random ops against an arithmetic model, and corner sequences.
module tb_seq_divider16;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, div_by_zero;
    logic [15:0] dividend, divisor, quotient, remainder;
    int          tests = 0, fails = 0;

    seq_divider16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, q, r;
        logic        dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, b, output logic [15:0] q, r, output logic dz);
        int sa, sb;
        dz = b == 16'd0;
        if (dz) begin
            q = 16'hFFFF;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end
    endfunction

    task automatic do_op(input logic [15:0] a, b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_on_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic op_check(input string name, input logic [15:0] a, b);
        logic [15:0] q, r;
        logic        dz;
        int          lat;
        model(a, b, q, r, dz);
        do_op(a, b, lat);
        chk({name, "_lat"}, 32'(lat), (b == 16'd0) ? 32'd0 : 32'd17);
        chk({name, "_q"}, 32'(quotient), 32'(q));
        chk({name, "_r"}, 32'(remainder), 32'(r));
        chk({name, "_dz"}, 32'(div_by_zero), 32'(dz));
        @(posedge clk);
        #1 chk({name, "_done_pulse"}, 32'({done, busy}), 32'd0);
        chk({name, "_hold_q"}, 32'(quotient), 32'(q));
    endtask

    initial begin
        vec_t vt[6];
        logic [15:0] q, r, a, b;
        int   nd, lat;
`ifdef SEQ_DIVIDER_SIGNED_EN
        vt[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
        vt[1] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
        vt[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vt[3] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vt[4] = '{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
        vt[5] = '{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0};
`else
        vt[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vt[2] = '{16'h0005, 16'hFFFF, 16'h0000, 16'h0005, 1'b0};
        vt[3] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vt[4] = '{16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0};
        vt[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
`endif
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", 32'({busy, done, div_by_zero}), 32'd0);
        chk("reset_results", {quotient, remainder}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vt[i].a, vt[i].b, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), vt[i].dz ? 32'd0 : 32'd17);
            chk($sformatf("vec%0d_q", i), 32'(quotient), 32'(vt[i].q));
            chk($sformatf("vec%0d_r", i), 32'(remainder), 32'(vt[i].r));
            chk($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vt[i].dz));
            @(posedge clk);
            #1 chk($sformatf("vec%0d_done_pulse", i), 32'({done, busy}), 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 3));
                1: b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            op_check($sformatf("rand%0d", i), a, b);
        end

        // start during RUN must not recapture operands
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        q = '0;
        r = '0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                nd++;
                q = quotient;
                r = remainder;
            end
            @(posedge clk);
            #1;
        end
        chk("busy_reject_ndone", 32'(nd), 32'd1);
        chk("busy_reject_q", 32'(q), 32'd14);
        chk("busy_reject_r", 32'(r), 32'd2);
        chk("busy_reject_idle", 32'(busy), 32'd0);

        // reset in the middle of RUN
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_flags", 32'({busy, done, div_by_zero}), 32'd0);
        chk("midrst_results", {quotient, remainder}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        op_check("after_rst", 16'd9, 16'd2);

        // start held through the FINISH cycle is taken on the following IDLE edge
        do_op(16'd200, 16'd9, lat);
        chk("fin_first_q", 32'(quotient), 32'd22);
        dividend = 16'd77; divisor = 16'd4; start = 1'b1;
        @(posedge clk);
        #1 chk("fin_start_ignored", 32'({busy, done}), 32'd0);
        chk("fin_hold_q", 32'(quotient), 32'd22);
        @(posedge clk);
        #1 start = 1'b0;
        chk("fin_next_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("fin_second_lat", 32'(lat), 32'd17);
        chk("fin_second_q", 32'(quotient), 32'd19);
        chk("fin_second_r", 32'(remainder), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
